fifo_reader: RTL and testbench
==============================

// Module: fifo_reader
// PURPOSE
//  Read-side engine for the codebase's `fifo` (B-bit words). It pops a word whenever the FIFO
//  is non-empty and presents it downstream with a valid/ready handshake. After each accepted
//  word it inserts a programmable gap of idle cycles.
//  Counterpart of the debounced-switch writer: the writer fills `fifo`, this block drains it
//  automatically (e.g. into LEDs or a TX stage).
// PARAMETERS
//  B      4   data word width; must match the fifo's B
//  GAP    3   idle cycles inserted after each accepted word (0 = back-to-back)
//  GAP_W  2   gap counter width; 2**GAP_W > GAP
//  CNT_W  8   width of the delivered-word counter
// PORTS
//  clk        in   1      system clock; the only clock
//  reset      in   1      synchronous, active-high reset
//  empty      in   1      fifo empty flag
//  rd_data    in   B      fifo head word; valid combinationally while empty=0 (fall-through)
//  rd         out  1      pop strobe to fifo; one cycle per word
//  out_data   out  B      captured word; stable while out_valid=1
//  out_valid  out  1      out_data holds an undelivered word
//  out_ready  in   1      downstream accepts the word on a cycle with out_valid&out_ready
//  busy       out  1      FSM is not in IDLE
//  word_cnt   out  CNT_W  words accepted downstream since reset; wraps modulo 2**CNT_W
// BEHAVIOUR
//  - Reset (synchronous, active-high, all registers): state=IDLE, rd=0, out_valid=0,
//    out_data=0, busy=0, word_cnt=0, gap counter=0.
//  - All outputs are registered or decoded from the Moore state only. No input reaches an
//    output combinationally.
//  - States and transitions:
//    IDLE  : rd=0. If empty=0, go to FETCH next cycle.
//    FETCH : rd=1 for exactly this one cycle.
//            At the closing edge: out_data<=rd_data, out_valid<=1, go to HOLD.
//    HOLD  : out_valid=1. On a cycle with out_ready=1: out_valid<=0, word_cnt<=word_cnt+1.
//            Then go to GAP, or to IDLE if GAP==0. Otherwise stay in HOLD.
//    GAP   : counter counts 0..GAP-1, then returns to IDLE with the counter cleared to 0.
//  - Latency: empty falls at edge t. rd is high during cycle t+1. out_valid rises at edge t+2.
//  - Throughput with out_ready tied to 1: one word per 3+GAP cycles.
//  - Only FETCH asserts rd, so rd can never be asserted while empty=1.
//    In FETCH the fifo cannot have become empty, because this block is its sole reader.
//  - out_ready while out_valid=0 is ignored. out_data never changes while out_valid=1.
//  - Simultaneous fifo write and FETCH pop: no interaction; the fifo handles it.
//  - Reset mid-operation (any state): back to IDLE next cycle with the values above.
//    A word already popped and not yet accepted is discarded.
//  - word_cnt wraps 2**CNT_W-1 -> 0 with no flag.
//  - The block never reads `full`.
// STRUCTURE
//  - Shared package/header `fifo_pkg`: state encodings (IDLE=2'b00, FETCH=2'b01, HOLD=2'b10,
//    GAP=2'b11) and default B, so the writer, reader and test top share one definition.
//  - One natural sub-module: `gap_counter`, parameters GAP and GAP_W.
//    Inputs: clk, reset, start. Output: done (one-cycle pulse).
//    Everything else stays in a single FSM plus datapath register.
//  - System-level test top instantiates `fifo` and `fifo_reader` together. The fifo's rd
//    port is driven only by fifo_reader.
// TESTING
//  1. Reset with fifo empty, hold for 10 cycles -> rd=0, out_valid=0, busy=0, word_cnt=0
//     throughout.
//  2. Write 4'hA into an empty fifo, out_ready=1, GAP=3 -> one rd pulse 1 cycle after empty
//     falls; out_data=4'hA with out_valid=1 for one cycle; word_cnt=1; busy low 3 cycles later.
//  3. Preload 4'h1,4'h2,4'h3; out_ready=1; GAP=0 -> out_data sequence 1,2,3 in order,
//     exactly 3 cycles apart, 3 rd pulses, word_cnt=3, empty=1 at the end.
//  4. Preload 4'h5; hold out_ready=0 for 20 cycles, then raise it ->
//     out_valid and out_data=4'h5 stable for all 20 cycles; no second rd pulse; word_cnt
//     goes 0->1 only on the accept cycle.
//  5. Assert reset while in HOLD with out_data=4'h7 -> next cycle out_valid=0, out_data=0,
//     rd=0, word_cnt=0. The fifo (also reset) stays empty and no rd follows.
//  6. CNT_W=2; stream 5 words with out_ready=1 -> word_cnt sequence 1,2,3,0,1.
//     Checker asserts rd=0 whenever empty=1 on every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo writer/reader pair: FSM state encoding and default word width.
package fifo_pkg;

    localparam int FIFO_B = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_GAP   = 2'b11
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/gap_counter.sv
// Idle-gap timer: after a start pulse it runs for GAP cycles and pulses done on the last one.
module gap_counter #(
    parameter int GAP   = 3,
    parameter int GAP_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    generate
        if (GAP == 0) begin : g_no_gap
            // No gap requested: the reader skips its GAP state, so the timer is never needed.
            logic w_unused;
            assign w_unused = clk ^ reset ^ start;
            assign done     = 1'b0;
        end else begin : g_gap
            localparam logic [GAP_W-1:0] LAST = GAP_W'(GAP - 1);

            logic [GAP_W-1:0] r_cnt;
            logic             r_run;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_run <= 1'b0;
                end else if (start) begin
                    r_cnt <= '0;
                    r_run <= 1'b1;
                end else if (r_run) begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        r_run <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + GAP_W'(1);
                    end
                end
            end

            assign done = r_run && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/fifo_reader.sv
// Drains a fall-through fifo one word at a time, offers each word on a valid/ready port,
// then waits a programmable number of idle cycles before fetching the next one.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int B     = FIFO_B,
    parameter int GAP   = 3,
    parameter int GAP_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             empty,
    input  logic [B-1:0]     rd_data,
    output logic             rd,
    output logic [B-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    state_t           r_state;
    state_t           w_state_next;
    logic [B-1:0]     r_out_data;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_word_cnt;
    logic             w_accept;
    logic             w_gap_done;

    assign w_accept = (r_state == ST_HOLD) && r_out_valid && out_ready;

    gap_counter #(
        .GAP   (GAP),
        .GAP_W (GAP_W)
    ) u_gap_counter (
        .clk   (clk),
        .reset (reset),
        .start (w_accept),
        .done  (w_gap_done)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (!empty) w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_HOLD;
            ST_HOLD:  if (w_accept) w_state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_gap_done) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            // The fifo head is captured on the same edge that completes the pop.
            if (r_state == ST_FETCH) begin
                r_out_data  <= rd_data;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign rd        = (r_state == ST_FETCH);
    assign busy      = state_is_busy(r_state);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_fifo_reader.sv
// Two readers (GAP=3/CNT_W=8 and GAP=0/CNT_W=2), each fed by a simple fifo stub, checked
// against a word-order scoreboard and directed timing tables.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] wr = 2'b00;
    logic [3:0] wr_data [2];
    logic [1:0] empty, rd, out_valid, busy;
    logic [1:0] out_ready = 2'b00;
    logic [3:0] rd_data_a, rd_data_b, out_data_a, out_data_b;
    logic [7:0] word_cnt_a;
    logic [1:0] word_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_reader #(.B(4), .GAP(3), .GAP_W(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .empty(empty[0]), .rd_data(rd_data_a), .rd(rd[0]),
        .out_data(out_data_a), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .word_cnt(word_cnt_a));

    fifo_reader #(.B(4), .GAP(0), .GAP_W(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .empty(empty[1]), .rd_data(rd_data_b), .rd(rd[1]),
        .out_data(out_data_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .word_cnt(word_cnt_b));

    // Fall-through fifo stubs, one per reader.
    logic [3:0] fmem [2][16];
    logic [3:0] fwp [2];
    logic [3:0] frp [2];
    int         fcnt [2];

    always @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                fwp[ch]  <= 4'd0;
                frp[ch]  <= 4'd0;
                fcnt[ch] <= 0;
            end else begin
                if (wr[ch]) begin
                    fmem[ch][fwp[ch]] <= wr_data[ch];
                    fwp[ch] <= fwp[ch] + 4'd1;
                end
                if (rd[ch]) frp[ch] <= frp[ch] + 4'd1;
                fcnt[ch] <= fcnt[ch] + int'(wr[ch]) - int'(rd[ch]);
            end
        end
    end

    assign empty[0]  = (fcnt[0] == 0);
    assign empty[1]  = (fcnt[1] == 0);
    assign rd_data_a = fmem[0][frp[0]];
    assign rd_data_b = fmem[1][frp[1]];

    // Reference model: words must come out in write order, held until accepted,
    // and word_cnt equals the number of accepts since reset modulo 2**CNT_W.
    logic [3:0] exp_mem [2][256];
    int         exp_wr [2];
    int         exp_rd [2];
    int         exp_cnt [2];
    int         rd_cnt [2];
    logic       prev_hold [2];
    logic [3:0] prev_data [2];

    logic [1:0] s_rd, s_empty, s_valid, s_busy;
    logic [3:0] s_data [2];
    logic [7:0] s_wc [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // Sample one cycle at the falling edge, update the scoreboard, then move to just after
    // the next rising edge where the tests change inputs.
    task automatic step();
        int mask;
        @(negedge clk);
        s_rd      = rd;
        s_empty   = empty;
        s_valid   = out_valid;
        s_busy    = busy;
        s_data[0] = out_data_a;
        s_data[1] = out_data_b;
        s_wc[0]   = word_cnt_a;
        s_wc[1]   = {6'd0, word_cnt_b};
        for (int ch = 0; ch < 2; ch++) begin
            mask = (ch == 0) ? 255 : 3;
            if (reset) begin
                exp_rd[ch]    = exp_wr[ch];
                exp_cnt[ch]   = 0;
                prev_hold[ch] = 1'b0;
            end else begin
                n_checks++;
                if (s_rd[ch] && s_empty[ch]) begin
                    n_fail++;
                    $display("FAIL rd_while_empty ch%0d: rd=%b empty=%b, rd must be 0 when empty",
                             ch, s_rd[ch], s_empty[ch]);
                end
                n_checks++;
                if (s_wc[ch] !== 8'(exp_cnt[ch] & mask)) begin
                    n_fail++;
                    $display("FAIL word_cnt ch%0d: got %0d, expected %0d", ch, s_wc[ch],
                             exp_cnt[ch] & mask);
                end
                if (prev_hold[ch]) begin
                    n_checks++;
                    if (s_valid[ch] !== 1'b1 || s_data[ch] !== prev_data[ch]) begin
                        n_fail++;
                        $display("FAIL hold_stable ch%0d: valid=%b data=%h, expected valid=1 data=%h",
                                 ch, s_valid[ch], s_data[ch], prev_data[ch]);
                    end
                end
                if (s_rd[ch] === 1'b1) rd_cnt[ch]++;
                if (wr[ch]) begin
                    exp_mem[ch][exp_wr[ch] % 256] = wr_data[ch];
                    exp_wr[ch]++;
                end
                if (s_valid[ch] === 1'b1 && out_ready[ch]) begin
                    n_checks++;
                    if (exp_rd[ch] == exp_wr[ch]) begin
                        n_fail++;
                        $display("FAIL accept_unexpected ch%0d: data=%h accepted, expected no word pending",
                                 ch, s_data[ch]);
                    end else if (s_data[ch] !== exp_mem[ch][exp_rd[ch] % 256]) begin
                        n_fail++;
                        $display("FAIL data_order ch%0d: got %h, expected %h", ch, s_data[ch],
                                 exp_mem[ch][exp_rd[ch] % 256]);
                    end
                    if (exp_rd[ch] != exp_wr[ch]) exp_rd[ch]++;
                    exp_cnt[ch]++;
                end
                prev_hold[ch] = (s_valid[ch] === 1'b1) && !out_ready[ch];
                prev_data[ch] = s_data[ch];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr    = 2'b00;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 20; c++) begin
            if (c == 10) reset = 1'b0;
            step();
            for (int ch = 0; ch < 2; ch++) begin
                n_checks++;
                if ({s_rd[ch], s_valid[ch], s_busy[ch]} !== 3'b000 || s_wc[ch] !== 8'd0) begin
                    n_fail++;
                    $display("FAIL reset_state ch%0d cyc%0d: rd=%b valid=%b busy=%b word_cnt=%0d, expected all 0",
                             ch, c, s_rd[ch], s_valid[ch], s_busy[ch], s_wc[ch]);
                end
            end
        end
    endtask

    task automatic test_single_word();
        int pulses;
        do_reset();
        out_ready[0] = 1'b1;
        wr[0] = 1'b1;
        wr_data[0] = 4'hA;
        step();
        wr[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_rd[0] === 1'b1) pulses++;
            n_checks++;
            if (s_rd[0] !== (k == 1) || s_valid[0] !== (k == 2) || s_busy[0] !== (k >= 1 && k <= 5)
                || s_wc[0] !== ((k >= 3) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL single_timing k=%0d: rd=%b valid=%b busy=%b wc=%0d, expected rd=%b valid=%b busy=%b wc=%0d",
                         k, s_rd[0], s_valid[0], s_busy[0], s_wc[0], k == 1, k == 2,
                         k >= 1 && k <= 5, (k >= 3) ? 1 : 0);
            end
            if (k == 2) begin
                n_checks++;
                if (s_data[0] !== 4'hA) begin
                    n_fail++;
                    $display("FAIL single_data: got %h, expected a", s_data[0]);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL single_rd_pulses: got %0d, expected 1", pulses);
        end
    endtask

    // Pushes n consecutive words on one channel with out_ready=1 and checks accept spacing.
    task automatic test_stream(input int ch, input int n, input int spacing, input string name);
        int acc_cyc [8];
        int acc_dat [8];
        int nacc;
        int rd0;
        do_reset();
        out_ready[ch] = 1'b1;
        rd0  = rd_cnt[ch];
        nacc = 0;
        for (int j = 0; j < 40; j++) begin
            wr[ch] = (j < n);
            wr_data[ch] = 4'(j + 1);
            step();
            if (s_valid[ch] === 1'b1) begin
                if (nacc < 8) begin
                    acc_cyc[nacc] = j;
                    acc_dat[nacc] = int'(s_data[ch]);
                end
                nacc++;
            end
        end
        wr[ch] = 1'b0;
        n_checks++;
        if (nacc != n || rd_cnt[ch] - rd0 != n) begin
            n_fail++;
            $display("FAIL %s_count: accepts=%0d rd_pulses=%0d, expected %0d each", name, nacc,
                     rd_cnt[ch] - rd0, n);
        end
        for (int i = 0; i < n && i < nacc; i++) begin
            n_checks++;
            if (acc_dat[i] != i + 1 || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != spacing)) begin
                n_fail++;
                $display("FAIL %s_word%0d: data=%0d gap=%0d, expected data=%0d gap=%0d", name, i,
                         acc_dat[i], (i > 0) ? acc_cyc[i] - acc_cyc[i-1] : 0, i + 1, spacing);
            end
        end
        n_checks++;
        if (s_wc[ch] !== 8'(n) || s_empty[ch] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_end: word_cnt=%0d empty=%b, expected word_cnt=%0d empty=1", name,
                     s_wc[ch], s_empty[ch], n);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        do_reset();
        out_ready[0] = 1'b0;
        wr[0] = 1'b1;
        wr_data[0] = 4'h5;
        step();
        wr[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_valid[0] === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_valid_timeout: out_valid=0 after 10 cycles, expected 1");
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (s_valid[0] !== 1'b1 || s_data[0] !== 4'h5 || s_rd[0] !== 1'b0 || s_wc[0] !== 8'd0) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h rd=%b wc=%0d, expected 1 5 0 0",
                         i, s_valid[0], s_data[0], s_rd[0], s_wc[0]);
            end
        end
        out_ready[0] = 1'b1;
        step();
        n_checks++;
        if (s_valid[0] !== 1'b1 || s_data[0] !== 4'h5 || s_wc[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_accept: valid=%b data=%h wc=%0d, expected 1 5 0", s_valid[0],
                     s_data[0], s_wc[0]);
        end
        step();
        n_checks++;
        if (s_valid[0] !== 1'b0 || s_wc[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_after: valid=%b wc=%0d, expected 0 1", s_valid[0], s_wc[0]);
        end
    endtask

    task automatic test_reset_in_hold();
        bit found;
        do_reset();
        out_ready[0] = 1'b0;
        wr[0] = 1'b1;
        wr_data[0] = 4'h7;
        step();
        wr[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_valid[0] === 1'b1) found = 1;
        end
        n_checks++;
        if (!found || s_data[0] !== 4'h7) begin
            n_fail++;
            $display("FAIL mid_hold: valid=%b data=%h, expected 1 7", s_valid[0], s_data[0]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (s_valid[0] !== 1'b0 || s_data[0] !== 4'h0 || s_rd[0] !== 1'b0 || s_wc[0] !== 8'd0
                || s_busy[0] !== 1'b0 || s_empty[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_reset cyc%0d: valid=%b data=%h rd=%b wc=%0d busy=%b empty=%b, expected 0 0 0 0 0 1",
                         i, s_valid[0], s_data[0], s_rd[0], s_wc[0], s_busy[0], s_empty[0]);
            end
        end
    endtask

    task automatic test_wrap();
        int  rec [8];
        int  exp_seq [5] = '{1, 2, 3, 0, 1};
        int  nrec;
        bit  pending;
        do_reset();
        out_ready[1] = 1'b1;
        nrec = 0;
        pending = 0;
        for (int j = 0; j < 40; j++) begin
            wr[1] = (j < 5);
            wr_data[1] = 4'(j + 8);
            step();
            if (pending) begin
                if (nrec < 8) rec[nrec] = int'(s_wc[1]);
                nrec++;
                pending = 0;
            end
            if (s_valid[1] === 1'b1) pending = 1;
        end
        wr[1] = 1'b0;
        n_checks++;
        if (nrec != 5) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d accepts, expected 5", nrec);
        end
        for (int i = 0; i < 5 && i < nrec; i++) begin
            n_checks++;
            if (rec[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL wrap_seq%0d: word_cnt=%0d, expected %0d", i, rec[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_random();
        bit done;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                wr[ch] = (fcnt[ch] < 12) && ($urandom_range(0, 2) == 0);
                wr_data[ch] = 4'($urandom);
                out_ready[ch] = 1'($urandom_range(0, 1));
            end
            step();
        end
        wr = 2'b00;
        out_ready = 2'b11;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            done = (exp_rd[0] == exp_wr[0]) && (exp_rd[1] == exp_wr[1]) && (s_busy == 2'b00);
        end
        for (int ch = 0; ch < 2; ch++) begin
            n_checks++;
            if (exp_rd[ch] != exp_wr[ch] || s_busy[ch] !== 1'b0) begin
                n_fail++;
                $display("FAIL random_drain ch%0d: %0d words undelivered busy=%b, expected 0 and 0",
                         ch, exp_wr[ch] - exp_rd[ch], s_busy[ch]);
            end
        end
    endtask

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            exp_wr[ch]    = 0;
            exp_rd[ch]    = 0;
            exp_cnt[ch]   = 0;
            rd_cnt[ch]    = 0;
            prev_hold[ch] = 1'b0;
            prev_data[ch] = 4'h0;
            wr_data[ch]   = 4'h0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_stream(1, 3, 3, "gap0_stream");
        test_stream(0, 4, 6, "gap3_throughput");
        test_backpressure();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
